// File: rtl/ppm_decoder.sv
// Receiver for 1-of-4 PPM frames: SOF lock, MSB-pair-first byte assembly, EOF/abort detection.
// Define PPM_DECODER_GLITCH_FILTER_EN for majority-of-3 slot sampling and glitch-proof edge arming.
module ppm_decoder #(
   parameter int unsigned SLOT_CLKS = 8,
   parameter int unsigned MAX_BYTES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ppm_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_done,
   output logic       frame_err,
   output logic [4:0] byte_count,
   output logic       busy
);
   localparam int unsigned CW = $clog2(SLOT_CLKS);
   localparam logic [CW-1:0] HALF = CW'(SLOT_CLKS / 2);
   localparam logic [CW-1:0] LAST = CW'(SLOT_CLKS - 1);
   localparam logic [4:0] MAX_CNT = 5'(MAX_BYTES);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] HUNT    = 2'd1;
   localparam logic [1:0] SOF_CHK = 2'd2;
   localparam logic [1:0] DATA    = 2'd3;

   localparam logic [3:0] PAT_SOF = 4'b0001;
   localparam logic [3:0] PAT_EOF = 4'b1000;

   logic          sync1_q, sync2_q, prev_q;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    slot_idx_q, slot_idx_d;
   logic [2:0]    pat_q, pat_d;
   logic [1:0]    phase_q, phase_d;
   logic [5:0]    byte_sr_q, byte_sr_d;
   logic [7:0]    data_out_q, data_out_d;
   logic [4:0]    byte_count_q, byte_count_d;
   logic          busy_q, busy_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic       fall, arm, slot_val, sample, last_slot;
   logic [3:0] pat;
   logic       sym_ok;
   logic [1:0] sym_val;

   assign fall = prev_q & ~sync2_q;

`ifdef PPM_DECODER_GLITCH_FILTER_EN
   // sync1_q is the next cycle's sync2_q, so the 3-sample window closes without extra latency.
   assign arm      = fall & ~sync1_q;
   assign slot_val = (prev_q & sync2_q) | (prev_q & sync1_q) | (sync2_q & sync1_q);
`else
   assign arm      = fall;
   assign slot_val = sync2_q;
`endif

   assign sample    = (cnt_q == HALF);
   assign last_slot = sample && (slot_idx_q == 2'd3);
   assign pat       = {pat_q, slot_val};

   always_comb begin
      sym_ok  = 1'b1;
      sym_val = 2'd0;
      case (pat)
         4'b0111: sym_val = 2'd0;
         4'b1011: sym_val = 2'd1;
         4'b1101: sym_val = 2'd2;
         4'b1110: sym_val = 2'd3;
         default: sym_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      slot_idx_d   = slot_idx_q;
      pat_d        = pat_q;
      phase_d      = phase_q;
      byte_sr_d    = byte_sr_q;
      data_out_d   = data_out_q;
      byte_count_d = byte_count_q;
      busy_d       = busy_q;
      valid_d      = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (sync2_q) state_d = HUNT;
         end
         HUNT: begin
            if (arm) begin
               // The edge cycle is count 0 of slot 0.
               state_d    = SOF_CHK;
               cnt_d      = CW'(1);
               slot_idx_d = 2'd0;
               pat_d      = 3'd0;
            end
         end
         SOF_CHK, DATA: begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (sample) begin
               pat_d      = pat[2:0];
               slot_idx_d = slot_idx_q + 2'd1;
            end
            if (last_slot) begin
               if (state_q == SOF_CHK) begin
                  if (pat == PAT_SOF) begin
                     state_d      = DATA;
                     busy_d       = 1'b1;
                     byte_count_d = 5'd0;
                     phase_d      = 2'd0;
                  end else begin
                     state_d = IDLE;
                  end
               end else if (sym_ok) begin
                  byte_sr_d = {byte_sr_q[3:0], sym_val};
                  phase_d   = phase_q + 2'd1;
                  if (phase_q == 2'd3) begin
                     if (byte_count_q == MAX_CNT) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                     end else begin
                        data_out_d   = {byte_sr_q, sym_val};
                        valid_d      = 1'b1;
                        byte_count_d = byte_count_q + 5'd1;
                     end
                  end
               end else begin
                  if ((pat == PAT_EOF) && (byte_count_q != 5'd0) && (phase_q == 2'd0)) begin
                     done_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         prev_q       <= 1'b0;
         state_q      <= IDLE;
         cnt_q        <= '0;
         slot_idx_q   <= 2'd0;
         pat_q        <= 3'd0;
         phase_q      <= 2'd0;
         byte_sr_q    <= 6'd0;
         data_out_q   <= 8'd0;
         byte_count_q <= 5'd0;
         busy_q       <= 1'b0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         sync1_q      <= ppm_in;
         sync2_q      <= sync1_q;
         prev_q       <= sync2_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         slot_idx_q   <= slot_idx_d;
         pat_q        <= pat_d;
         phase_q      <= phase_d;
         byte_sr_q    <= byte_sr_d;
         data_out_q   <= data_out_d;
         byte_count_q <= byte_count_d;
         busy_q       <= busy_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = valid_q;
   assign frame_done = done_q;
   assign frame_err  = err_q;
   assign byte_count = byte_count_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_ppm_decoder.sv
// Bench for ppm_decoder: directed and random frames checked against a frame-level decode model.
// With PPM_DECODER_GLITCH_FILTER_EN defined, a glitched frame is also run.
module tb_ppm_decoder;
   localparam int unsigned SLOT_CLKS = 8;
   localparam int unsigned MAX_BYTES = 16;
   localparam logic [3:0] SOF = 4'b0001;
   localparam logic [3:0] EOF = 4'b1000;
   localparam int KIND_NONE = 0;
   localparam int KIND_DONE = 1;
   localparam int KIND_ERR  = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ppm_in = 1'b1;
   logic [7:0] data_out;
   logic       data_valid, frame_done, frame_err, busy;
   logic [4:0] byte_count;

   int tests = 0;
   int fails = 0;
   logic [3:0] sym_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int exp_kind, exp_cnt, last_cnt, n_send, n_done, n_err;
   logic busy_prev = 1'b0;
   bit glitch_en = 1'b0;
   logic [3:0] bad_pats [11] = '{4'b0000, 4'b1111, 4'b0011, 4'b0101, 4'b1001, 4'b0001,
                                  4'b1100, 4'b0110, 4'b1010, 4'b0010, 4'b0100};

   ppm_decoder #(.SLOT_CLKS(SLOT_CLKS), .MAX_BYTES(MAX_BYTES)) dut (
      .clk(clk), .rst_n(rst_n), .ppm_in(ppm_in), .data_out(data_out),
      .data_valid(data_valid), .frame_done(frame_done), .frame_err(frame_err),
      .byte_count(byte_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_prev = 1'b0;
      end else begin
         if (data_valid) begin
            got_q.push_back(data_out);
            chk("valid_while_busy", busy, 1);
            chk("valid_done_excl", frame_done, 0);
         end
         if (frame_done) begin
            n_done++;
            chk("done_err_excl", frame_err, 0);
         end
         if (frame_err) n_err++;
         if (frame_done || frame_err) begin
            chk("busy_low_at_end", busy, 0);
            chk("busy_high_before_end", busy_prev, 1);
         end
         busy_prev = busy;
      end
   end

   task automatic add_byte(input logic [7:0] b);
      logic [1:0] d;
      for (int k = 0; k < 4; k++) begin
         d = b[7-2*k -: 2];
         sym_q.push_back(~(4'b1000 >> d));
      end
   endtask

   // Frame-level decode: returns expected bytes, final pulse kind and how many symbols to send.
   task automatic model();
      int cnt, ph, zeros, d;
      logic [7:0] acc;
      logic [3:0] p;
      cnt = 0; ph = 0; acc = 8'd0;
      exp_q.delete();
      exp_kind = KIND_NONE;
      n_send = sym_q.size();
      if (sym_q[0] != SOF) begin
         exp_cnt = last_cnt;
         return;
      end
      for (int i = 1; i <= sym_q.size(); i++) begin
         p = (i < sym_q.size()) ? sym_q[i] : 4'b1111;
         n_send = (i < sym_q.size()) ? i + 1 : sym_q.size();
         zeros = 0; d = 0;
         for (int s = 0; s < 4; s++) if (!p[3-s]) begin zeros++; d = s; end
         if (zeros == 1) begin
            acc = acc * 4 + 8'(d);
            ph++;
            if (ph == 4) begin
               ph = 0;
               if (cnt == MAX_BYTES) begin exp_kind = KIND_ERR; break; end
               exp_q.push_back(acc);
               cnt++;
            end
         end else if (p == EOF) begin
            exp_kind = (cnt >= 1 && ph == 0) ? KIND_DONE : KIND_ERR;
            break;
         end else begin
            exp_kind = KIND_ERR;
            break;
         end
      end
      exp_cnt = cnt;
      last_cnt = cnt;
   endtask

   task automatic drive_slot(input logic lvl);
      for (int c = 0; c < SLOT_CLKS; c++) begin
         ppm_in = (glitch_en && lvl && c == SLOT_CLKS / 2) ? 1'b0 : lvl;
         @(posedge clk); #1;
      end
   endtask

   task automatic send_syms(input int n);
      for (int i = 0; i < n; i++)
         for (int s = 0; s < 4; s++) drive_slot(sym_q[i][3-s]);
      ppm_in = 1'b1;
   endtask

   task automatic run_frame(input string name);
      model();
      got_q.delete();
      n_done = 0;
      n_err = 0;
      send_syms(n_send);
      repeat (8 * SLOT_CLKS) @(posedge clk);
      #1;
      chk({name, ".nbytes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({name, ".byte"}, got_q[i], exp_q[i]);
      chk({name, ".done"}, n_done, (exp_kind == KIND_DONE) ? 1 : 0);
      chk({name, ".err"}, n_err, (exp_kind == KIND_ERR) ? 1 : 0);
      chk({name, ".byte_count"}, byte_count, exp_cnt);
      chk({name, ".busy_idle"}, busy, 0);
   endtask

   initial begin
      int nb, mode, idx;
      last_cnt = 0;
      #2;
      chk("rst.data_out", data_out, 0);
      chk("rst.data_valid", data_valid, 0);
      chk("rst.frame_done", frame_done, 0);
      chk("rst.frame_err", frame_err, 0);
      chk("rst.byte_count", byte_count, 0);
      chk("rst.busy", busy, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      sym_q.delete(); sym_q.push_back(SOF);
      add_byte(8'hA5); add_byte(8'h3C); sym_q.push_back(EOF);
      run_frame("a5_3c");
      if (got_q.size() == 2) begin
         chk("a5_3c.first", got_q[0], 8'hA5);
         chk("a5_3c.second", got_q[1], 8'h3C);
      end
      chk("a5_3c.count", byte_count, 2);

      sym_q.delete(); sym_q.push_back(SOF);
      add_byte(8'h96); sym_q.push_back(4'b1011); sym_q.push_back(4'b0111); sym_q.push_back(EOF);
      run_frame("partial_eof");
      chk("partial_eof.count", byte_count, 1);

      sym_q.delete(); sym_q.push_back(4'b0111);
      run_frame("lone_pulse");
      sym_q.delete(); sym_q.push_back(SOF); add_byte(8'h00); sym_q.push_back(EOF);
      run_frame("zero_byte");

      sym_q.delete(); sym_q.push_back(SOF); add_byte(8'h4E); sym_q.push_back(4'b1111);
      run_frame("hhhh_abort");

      sym_q.delete(); sym_q.push_back(SOF);
      for (int i = 0; i <= MAX_BYTES; i++) add_byte(8'(i * 17 + 3));
      sym_q.push_back(EOF);
      run_frame("overflow");
      chk("overflow.count", byte_count, MAX_BYTES);

      // Reset during the second symbol of a byte.
      sym_q.delete(); sym_q.push_back(SOF); add_byte(8'hFF); sym_q.push_back(EOF);
      send_syms(2);
      repeat (SLOT_CLKS + SLOT_CLKS / 2) @(posedge clk);
      #1;
      chk("midrst.busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.data_out", data_out, 0);
      chk("midrst.data_valid", data_valid, 0);
      chk("midrst.frame_done", frame_done, 0);
      chk("midrst.frame_err", frame_err, 0);
      chk("midrst.byte_count", byte_count, 0);
      chk("midrst.busy", busy, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      last_cnt = 0;
      repeat (6) @(posedge clk);
      #1;
      run_frame("after_rst");
      chk("after_rst.count", byte_count, 1);

`ifdef PPM_DECODER_GLITCH_FILTER_EN
      sym_q.delete(); sym_q.push_back(SOF); add_byte(8'hC9); add_byte(8'h1E); sym_q.push_back(EOF);
      glitch_en = 1'b1;
      run_frame("glitch");
      glitch_en = 1'b0;
`endif

      for (int f = 0; f < 25; f++) begin
         nb = ($urandom_range(0, 7) == 0) ? MAX_BYTES + 1 : int'($urandom_range(0, 5));
         mode = $urandom_range(0, 5);
         sym_q.delete(); sym_q.push_back(SOF);
         for (int i = 0; i < nb; i++) add_byte(8'($urandom));
         case (mode)
            3: begin
               repeat ($urandom_range(1, 3)) sym_q.push_back(~(4'b1000 >> $urandom_range(0, 3)));
               sym_q.push_back(EOF);
            end
            4: begin
               sym_q.push_back(EOF);
               idx = $urandom_range(1, sym_q.size() - 1);
               sym_q[idx] = bad_pats[$urandom_range(0, 10)];
            end
            5: ;
            default: sym_q.push_back(EOF);
         endcase
         run_frame("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
